rv_wbarb: RTL and testbench



---
 rtl/rv_wbarb_pkg.sv | 18 +
 rtl/rv_wbfifo.sv | 72 +++++++
 rtl/rv_wbarb.sv | 108 ++++++++++
 tb/tb_rv_wbarb.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_wbarb_pkg.sv
// Shared types for the write-back arbiter: register index/data words and the
// completion-buffer entry, plus the "does this index name a real register" test.
package rv_wbarb_pkg;

  typedef logic [4:0]  u5_t;
  typedef logic [31:0] u32_t;

  typedef struct packed {
    u5_t  rd;
    u32_t wd;
  } wbent_t;

  // r0 is hard-wired and indices past the tracked file have no storage.
  function automatic logic rd_valid(input u5_t rd, input int nregs);
    return (rd != 5'd0) && ({27'd0, rd} < 32'(nregs));
  endfunction

endpackage

// File: rtl/rv_wbfifo.sv
// In-order completion buffer. Head is read straight from the entry registers so
// a completion accepted on one edge can be written back on the very next edge.
module rv_wbfifo
  import rv_wbarb_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic                         clk,
  input  logic                         xreset,
  input  logic                         push,
  input  wbent_t                       wdata,
  input  logic                         pop,
  output wbent_t                       head,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(Depth + 1);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  wbent_t        mem_q [Depth];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(Depth - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign full    = (count_q == CW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!xreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entries are cleared on reset so the head never carries unknown data.
  for (genvar gi = 0; gi < Depth; gi++) begin : g_ent
    always_ff @(posedge clk) begin
      if (!xreset) begin
        mem_q[gi] <= '0;
      end else if (do_push && (wr_ptr_q == PW'(gi))) begin
        mem_q[gi] <= wdata;
      end
    end
  end

endmodule

// File: rtl/rv_wbarb.sv
// Register-file write-port arbiter: pipeline results first, buffered long-latency
// completions otherwise, with a per-register busy scoreboard for decode stalls.
module rv_wbarb
  import rv_wbarb_pkg::*;
#(
  parameter int Nregs = 16,
  parameter int Depth = 2
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic        p_we,
  input  logic [4:0]  p_rd,
  input  logic [31:0] p_wd,
  input  logic        l_iss,
  input  logic [4:0]  l_ird,
  input  logic        l_vld,
  input  logic [4:0]  l_rd,
  input  logic [31:0] l_wd,
  output logic        l_rdy,
  input  logic [4:0]  ars1,
  input  logic [4:0]  ars2,
  input  logic [4:0]  ard,
  output logic        busy1,
  output logic        busy2,
  output logic        busyd,
  output logic [4:0]  awd,
  output logic        we,
  output logic [31:0] wd
);

  localparam int CW = $clog2(Depth + 1);

  logic                 p_fire, pop, push;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count_unused;
  wbent_t               head;
  logic [Nregs-1:0]     busy_q, busy_d;
  logic [31:0]          busy_ext;

  // l_rdy depends only on registered occupancy and reset, never on l_vld.
  assign l_rdy  = xreset && !fifo_full;
  assign push   = l_vld && l_rdy;
  assign p_fire = xreset && p_we && rd_valid(p_rd, Nregs);
  assign pop    = xreset && !p_fire && !fifo_empty;

  rv_wbfifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk    (clk),
    .xreset (xreset),
    .push   (push),
    .wdata  ('{rd: l_rd, wd: l_wd}),
    .pop    (pop),
    .head   (head),
    .count  (fifo_count_unused),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // A popped entry for r0 or an untracked index still drains, just without a write.
  always_comb begin
    we  = 1'b0;
    awd = '0;
    wd  = '0;
    if (p_fire) begin
      we  = 1'b1;
      awd = p_rd;
      wd  = p_wd;
    end else if (pop && rd_valid(head.rd, Nregs)) begin
      we  = 1'b1;
      awd = head.rd;
      wd  = head.wd;
    end
  end

  // Bit 0 is never set; an issue landing on the same edge as the drain keeps the bit.
  for (genvar gi = 0; gi < Nregs; gi++) begin : g_sb
    if (gi == 0) begin : g_zero
      assign busy_d[gi] = 1'b0;
    end else begin : g_reg
      logic set_hit, clr_hit;
      assign set_hit    = l_iss && (l_ird == 5'(gi));
      assign clr_hit    = pop && (head.rd == 5'(gi));
      assign busy_d[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_q[gi]);
    end
  end

  always_ff @(posedge clk) begin
    if (!xreset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_bext
    if (gi > 0 && gi < Nregs) begin : g_in
      assign busy_ext[gi] = busy_q[gi];
    end else begin : g_out
      assign busy_ext[gi] = 1'b0;
    end
  end

  assign busy1 = xreset && busy_ext[ars1];
  assign busy2 = xreset && busy_ext[ars2];
  assign busyd = xreset && busy_ext[ard];

endmodule

// File: tb/tb_rv_wbarb.sv
// Bench for rv_wbarb: directed scenarios with fixed expectations, then random
// traffic checked against a queue-based model of the write-back rules.
module tb_rv_wbarb;

  localparam int NREGS = 16;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        xreset;
  logic        p_we, l_iss, l_vld, l_rdy;
  logic [4:0]  p_rd, l_ird, l_rd, ars1, ars2, ard, awd;
  logic [31:0] p_wd, l_wd, wd;
  logic        busy1, busy2, busyd, we;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  ent_t q[$];
  bit   mbusy [32];
  logic e_we, e_rdy, e_b1, e_b2, e_bd, m_pop, m_push;
  logic [4:0]  e_awd;
  logic [31:0] e_wd;

  always #5 clk = ~clk;

  rv_wbarb #(.Nregs(NREGS), .Depth(DEPTH)) dut (
    .clk(clk), .xreset(xreset),
    .p_we(p_we), .p_rd(p_rd), .p_wd(p_wd),
    .l_iss(l_iss), .l_ird(l_ird),
    .l_vld(l_vld), .l_rd(l_rd), .l_wd(l_wd), .l_rdy(l_rdy),
    .ars1(ars1), .ars2(ars2), .ard(ard),
    .busy1(busy1), .busy2(busy2), .busyd(busyd),
    .awd(awd), .we(we), .wd(wd)
  );

  function automatic bit vr(input logic [4:0] r);
    return (r != 5'd0) && (int'(r) < NREGS);
  endfunction

  task automatic idle();
    xreset = 1'b1; p_we = 1'b0; p_rd = '0; p_wd = '0;
    l_iss = 1'b0; l_ird = '0; l_vld = 1'b0; l_rd = '0; l_wd = '0;
    ars1 = '0; ars2 = '0; ard = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model: what the write port and status outputs must show for the current inputs.
  task automatic model_expect();
    bit pf;
    e_rdy = xreset && (q.size() < DEPTH);
    pf    = xreset && p_we && vr(p_rd);
    m_pop  = xreset && !pf && (q.size() > 0);
    m_push = xreset && l_vld && e_rdy;
    e_we = 1'b0; e_awd = '0; e_wd = '0;
    if (pf) begin
      e_we = 1'b1; e_awd = p_rd; e_wd = p_wd;
    end else if (m_pop && vr(q[0].rd)) begin
      e_we = 1'b1; e_awd = q[0].rd; e_wd = q[0].wd;
    end
    e_b1 = xreset && vr(ars1) && mbusy[ars1];
    e_b2 = xreset && vr(ars2) && mbusy[ars2];
    e_bd = xreset && vr(ard)  && mbusy[ard];
  endtask

  task automatic model_update();
    ent_t h;
    if (!xreset) begin
      q.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
    end else begin
      if (m_pop) begin
        h = q.pop_front();
        if (vr(h.rd)) mbusy[h.rd] = 1'b0;
      end
      if (m_push) q.push_back('{rd: l_rd, wd: l_wd});
      if (l_iss && vr(l_ird)) mbusy[l_ird] = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle();
    xreset = 1'b0; l_vld = 1'b1; l_rd = 5'd4; l_wd = 32'h1234;
    p_we = 1'b1; p_rd = 5'd3; p_wd = 32'hAAAA; l_iss = 1'b1; l_ird = 5'd5;
    ars1 = 5'd5; ars2 = 5'd3; ard = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({we, awd, wd, l_rdy, busy1, busy2, busyd} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: we=%b awd=%0d wd=%h rdy=%b busy=%b%b%b, want all 0",
                 we, awd, wd, l_rdy, busy1, busy2, busyd);
      end
      step();
    end
    idle();
    ars1 = 5'd5;
    #1;
    checks++;
    if (l_rdy !== 1'b1 || we !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: rdy=%b we=%b busy1=%b, want 1/0/0", l_rdy, we, busy1);
    end
    step();
  endtask

  task automatic test_round_trip();
    idle();
    l_iss = 1'b1; l_ird = 5'd5; ars1 = 5'd5;
    #1;
    checks++;
    if (busy1 !== 1'b0) begin
      failures++; $display("FAIL rt_issue_cycle: busy1=%b, want 0", busy1);
    end
    step();
    l_iss = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (busy1 !== 1'b1) begin
        failures++; $display("FAIL rt_busy_set: busy1=%b, want 1", busy1);
      end
      step();
    end
    l_vld = 1'b1; l_rd = 5'd5; l_wd = 32'hDEADBEEF;
    #1;
    checks++;
    if (we !== 1'b0 || l_rdy !== 1'b1) begin
      failures++; $display("FAIL rt_accept: we=%b rdy=%b, want 0/1", we, l_rdy);
    end
    step();
    l_vld = 1'b0;
    #1;
    checks++;
    if (we !== 1'b1 || awd !== 5'd5 || wd !== 32'hDEADBEEF || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL rt_write: we=%b awd=%0d wd=%h busy1=%b, want 1/5/deadbeef/1", we, awd, wd, busy1);
    end
    $display("rf write r%0d <= %h", awd, wd);
    step();
    #1;
    checks++;
    if (busy1 !== 1'b0 || we !== 1'b0) begin
      failures++; $display("FAIL rt_busy_clear: busy1=%b we=%b, want 0/0", busy1, we);
    end
    step();
  endtask

  task automatic test_priority();
    idle();
    l_iss = 1'b1; l_ird = 5'd7; l_vld = 1'b1; l_rd = 5'd7; l_wd = 32'h77;
    p_we = 1'b1; p_rd = 5'd3; p_wd = 32'h11; ard = 5'd7;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (we !== 1'b1 || awd !== 5'd3 || wd !== 32'h11) begin
        failures++; $display("FAIL prio_pipe%0d: we=%b awd=%0d wd=%h, want 1/3/11", i, we, awd, wd);
      end
      step();
      l_iss = 1'b0; l_vld = 1'b0;
    end
    p_we = 1'b0;
    #1;
    checks++;
    if (we !== 1'b1 || awd !== 5'd7 || wd !== 32'h77 || busyd !== 1'b1) begin
      failures++;
      $display("FAIL prio_drain: we=%b awd=%0d wd=%h busyd=%b, want 1/7/77/1", we, awd, wd, busyd);
    end
    step();
    #1;
    checks++;
    if (busyd !== 1'b0 || we !== 1'b0) begin
      failures++; $display("FAIL prio_clear: busyd=%b we=%b, want 0/0", busyd, we);
    end
    step();
  endtask

  task automatic test_full();
    idle();
    l_iss = 1'b1; l_ird = 5'd10; p_we = 1'b1; p_rd = 5'd2; p_wd = 32'h22;
    step();
    l_iss = 1'b0; l_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      l_rd = 5'(10 + i); l_wd = 32'hA0 + 32'(i * 16);
      #1;
      checks++;
      if (l_rdy !== 1'b1) begin
        failures++; $display("FAIL full_accept%0d: rdy=%b, want 1", i, l_rdy);
      end
      step();
    end
    l_rd = 5'd12; l_wd = 32'hC0;
    #1;
    checks++;
    if (l_rdy !== 1'b0 || we !== 1'b1 || awd !== 5'd2) begin
      failures++; $display("FAIL full_stall: rdy=%b we=%b awd=%0d, want 0/1/2", l_rdy, we, awd);
    end
    step();
    l_vld = 1'b0; p_we = 1'b0;
    #1;
    checks++;
    if (we !== 1'b1 || awd !== 5'd10 || wd !== 32'hA0 || l_rdy !== 1'b0) begin
      failures++;
      $display("FAIL full_drain0: we=%b awd=%0d wd=%h rdy=%b, want 1/10/a0/0", we, awd, wd, l_rdy);
    end
    step();
    #1;
    checks++;
    if (we !== 1'b1 || awd !== 5'd11 || wd !== 32'hB0 || l_rdy !== 1'b1) begin
      failures++;
      $display("FAIL full_drain1: we=%b awd=%0d wd=%h rdy=%b, want 1/11/b0/1", we, awd, wd, l_rdy);
    end
    step();
    #1;
    checks++;
    if (we !== 1'b0 || l_rdy !== 1'b1) begin
      failures++; $display("FAIL full_dropped: we=%b rdy=%b, want 0/1", we, l_rdy);
    end
    step();
  endtask

  task automatic test_collision();
    idle();
    l_iss = 1'b1; l_ird = 5'd9;
    step();
    l_iss = 1'b0; l_vld = 1'b1; l_rd = 5'd9; l_wd = 32'h99;
    step();
    l_vld = 1'b0; l_iss = 1'b1; l_ird = 5'd9; ard = 5'd9;
    #1;
    checks++;
    if (we !== 1'b1 || awd !== 5'd9 || busyd !== 1'b1) begin
      failures++; $display("FAIL coll_pop: we=%b awd=%0d busyd=%b, want 1/9/1", we, awd, busyd);
    end
    step();
    l_iss = 1'b0;
    #1;
    checks++;
    if (busyd !== 1'b1) begin
      failures++; $display("FAIL coll_set_wins: busyd=%b, want 1", busyd);
    end
    l_vld = 1'b1; l_rd = 5'd9; l_wd = 32'h9A;
    step();
    l_vld = 1'b0;
    step();
    #1;
    checks++;
    if (busyd !== 1'b0) begin
      failures++; $display("FAIL coll_final_clear: busyd=%b, want 0", busyd);
    end
    step();
  endtask

  task automatic test_rd0_range();
    idle();
    l_iss = 1'b1; l_ird = 5'd0;
    step();
    l_ird = 5'd20;
    step();
    l_iss = 1'b0; ars1 = 5'd0; ars2 = 5'd4; ard = 5'd20;
    p_we = 1'b1; p_rd = 5'd0; p_wd = 32'h5;
    #1;
    checks++;
    if ({busy1, busy2, busyd} !== 3'b000 || we !== 1'b0) begin
      failures++;
      $display("FAIL rd0_range: busy=%b%b%b we=%b, want 000/0", busy1, busy2, busyd, we);
    end
    p_we = 1'b0; l_vld = 1'b1; l_rd = 5'd0; l_wd = 32'h55;
    step();
    l_rd = 5'd6; l_wd = 32'h66;
    #1;
    checks++;
    if (we !== 1'b0 || l_rdy !== 1'b1) begin
      failures++; $display("FAIL rd0_pop: we=%b rdy=%b, want 0/1", we, l_rdy);
    end
    step();
    l_vld = 1'b0;
    #1;
    checks++;
    if (we !== 1'b1 || awd !== 5'd6 || wd !== 32'h66) begin
      failures++; $display("FAIL rd0_next: we=%b awd=%0d wd=%h, want 1/6/66", we, awd, wd);
    end
    step();
  endtask

  task automatic test_random();
    idle();
    xreset = 1'b0;
    #1;
    model_expect();
    @(posedge clk);
    model_update();
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      xreset = ($urandom_range(0, 99) >= 3);
      p_we   = ($urandom_range(0, 99) < 30);
      p_rd   = 5'($urandom_range(0, 18));
      p_wd   = $urandom;
      l_iss  = ($urandom_range(0, 99) < 40);
      l_ird  = 5'($urandom_range(0, 20));
      l_vld  = ($urandom_range(0, 99) < 50);
      l_rd   = 5'($urandom_range(0, 20));
      l_wd   = $urandom;
      ars1   = 5'($urandom_range(0, 20));
      ars2   = 5'($urandom_range(0, 20));
      ard    = 5'($urandom_range(0, 20));
      #1;
      model_expect();
      checks++;
      if ({we, awd, wd, l_rdy, busy1, busy2, busyd} !== {e_we, e_awd, e_wd, e_rdy, e_b1, e_b2, e_bd}) begin
        failures++;
        $display("FAIL rand_cyc%0d: we=%b awd=%0d wd=%h rdy=%b busy=%b%b%b, want we=%b awd=%0d wd=%h rdy=%b busy=%b%b%b",
                 n, we, awd, wd, l_rdy, busy1, busy2, busyd, e_we, e_awd, e_wd, e_rdy, e_b1, e_b2, e_bd);
      end
      if (we === 1'b1) $display("rf write r%0d <= %h", awd, wd);
      @(posedge clk);
      model_update();
      @(negedge clk);
    end
  endtask

  initial begin
    idle();
    xreset = 1'b0;
    @(negedge clk);
    test_reset();
    test_round_trip();
    test_priority();
    test_full();
    test_collision();
    test_rd0_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
